// File: rtl/memsum_pkg.sv
// rtl/memsum_pkg.sv - shared state encoding and register-map constants for the MemSum sum unit
package memsum_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        INIT_I = 4'd1,
        INIT_S = 4'd2,
        INIT_K = 4'd3,
        CMP    = 4'd4,
        ACC    = 4'd5,
        INC    = 4'd6,
        OUT    = 4'd7,
        DONE   = 4'd8
    } state_t;

    // Register file map: R0 reads as zero, R1 = i, R2 = sum, R3 = constant 1.
    localparam int R_ZERO = 0;
    localparam int R_I    = 1;
    localparam int R_SUM  = 2;
    localparam int R_ONE  = 3;

    // Loop bound used by the datapath comparator (RdData1 <= LIMIT).
    localparam int LIMIT  = 10;

endpackage

// File: rtl/memsum_cu.sv
// rtl/memsum_cu.sv - Moore control FSM sequencing the register file and sum datapath
module memsum_cu
    import memsum_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iStart,
    input  logic          iAlt,
    output logic [AW-1:0] oRAddr0,
    output logic [AW-1:0] oRAddr1,
    output logic [AW-1:0] oWAddr,
    output logic          oWe,
    output logic          oRSrcSel,
    output logic          oOutBufSel,
    output logic          oBusy,
    output logic          oDone
);

    state_t state;
    state_t state_nxt;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs depend only on the state register; every write lands on the edge leaving its state.
    always_comb begin
        state_nxt  = state;
        oRAddr0    = '0;
        oRAddr1    = '0;
        oWAddr     = '0;
        oWe        = 1'b0;
        oRSrcSel   = 1'b0;
        oOutBufSel = 1'b0;
        oBusy      = 1'b1;
        oDone      = 1'b0;

        case (state)
            IDLE: begin
                oBusy = 1'b0;
                if (iStart) begin
                    state_nxt = INIT_I;
                end
            end
            INIT_I: begin
                oWAddr    = AW'(R_I);
                oWe       = 1'b1;
                state_nxt = INIT_S;
            end
            INIT_S: begin
                oRAddr0   = AW'(R_ZERO);
                oRAddr1   = AW'(R_ZERO);
                oWAddr    = AW'(R_SUM);
                oWe       = 1'b1;
                oRSrcSel  = 1'b1;
                state_nxt = INIT_K;
            end
            INIT_K: begin
                oWAddr    = AW'(R_ONE);
                oWe       = 1'b1;
                state_nxt = CMP;
            end
            CMP: begin
                oRAddr1   = AW'(R_I);
                state_nxt = iAlt ? ACC : DONE;
            end
            ACC: begin
                oRAddr0   = AW'(R_SUM);
                oRAddr1   = AW'(R_I);
                oWAddr    = AW'(R_SUM);
                oWe       = 1'b1;
                oRSrcSel  = 1'b1;
                state_nxt = INC;
            end
            INC: begin
                oRAddr0   = AW'(R_I);
                oRAddr1   = AW'(R_ONE);
                oWAddr    = AW'(R_I);
                oWe       = 1'b1;
                oRSrcSel  = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                oRAddr0    = AW'(R_SUM);
                oOutBufSel = 1'b1;
                state_nxt  = CMP;
            end
            DONE: begin
                oRAddr0    = AW'(R_SUM);
                oOutBufSel = 1'b1;
                oBusy      = 1'b0;
                oDone      = 1'b1;
                if (iStart) begin
                    state_nxt = INIT_I;
                end
            end
            default: begin
                oBusy     = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memsum_cu.sv
// tb/tb_memsum_cu.sv - self-checking bench with behavioural register file and sum datapath
module tb_memsum_cu;
    import memsum_pkg::*;

    localparam int AW = 2;

    logic          iClk = 1'b0;
    logic          iRst;
    logic          iStart;
    logic          iAlt;
    logic [AW-1:0] oRAddr0;
    logic [AW-1:0] oRAddr1;
    logic [AW-1:0] oWAddr;
    logic          oWe;
    logic          oRSrcSel;
    logic          oOutBufSel;
    logic          oBusy;
    logic          oDone;

    logic          alt_force;
    logic          scr;
    logic [7:0]    rf [4];
    logic [7:0]    rd_data0;
    logic [7:0]    rd_data1;
    logic [7:0]    wdata;

    int total = 0;
    int bad   = 0;

    memsum_cu #(.AW(AW)) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iStart     (iStart),
        .iAlt       (iAlt),
        .oRAddr0    (oRAddr0),
        .oRAddr1    (oRAddr1),
        .oWAddr     (oWAddr),
        .oWe        (oWe),
        .oRSrcSel   (oRSrcSel),
        .oOutBufSel (oOutBufSel),
        .oBusy      (oBusy),
        .oDone      (oDone)
    );

    always #5 iClk = ~iClk;

    // Behavioural register file (R0 reads zero) and adder/comparator datapath.
    assign rd_data0 = (oRAddr0 == '0) ? 8'd0 : rf[oRAddr0];
    assign rd_data1 = (oRAddr1 == '0) ? 8'd0 : rf[oRAddr1];
    assign wdata    = oRSrcSel ? 8'(rd_data0 + rd_data1) : 8'd1;
    assign iAlt     = alt_force ? 1'b0 : (rd_data1 <= 8'(LIMIT));

    always @(posedge iClk) begin
        if (scr) begin
            for (int k = 1; k < 4; k++) rf[k] <= 8'($urandom);
        end else if (oWe && oWAddr != '0) begin
            rf[oWAddr] <= wdata;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3*AW+4:0] outs();
        return {oRAddr0, oRAddr1, oWAddr, oWe, oRSrcSel, oOutBufSel, oBusy, oDone};
    endfunction

    task automatic scramble();
        scr = 1'b1;
        @(posedge iClk); #1;
        scr = 1'b0;
    endtask

    // Starts a run (iStart must be sampled at the next edge) and checks it against
    // the arithmetic model: n loop iterations, 1+3+4n+1 edges, sums 1..k.
    task automatic run_once(input bit hold, input bit toggle, input int n, input string tag);
        int edges = 0;
        int busy_cnt = 0;
        int exp_edges = 5 + 4 * n;
        int s = 0;
        int q[$];
        int wq[$];
        bit seen_done = 0;
        iStart = 1'b1;
        while (edges < 200 && !seen_done) begin
            @(posedge iClk); #1;
            edges++;
            if (edges == 1) check_val({tag, "_first_busy"}, 32'(oBusy), 32'd1);
            if (oBusy) busy_cnt++;
            if (oWe) wq.push_back(int'(oWAddr));
            if (oOutBufSel && !oDone) q.push_back(int'(rd_data0));
            if (oDone) begin
                seen_done = 1;
            end else if (toggle) begin
                iStart = 1'($urandom);
            end else if (!hold) begin
                iStart = 1'b0;
            end
        end
        if (!hold) iStart = 1'b0;
        check_val({tag, "_done"}, 32'(seen_done), 32'd1);
        check_val({tag, "_edges"}, 32'(edges), 32'(exp_edges));
        check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_edges - 1));
        check_val({tag, "_writes"}, 32'(wq.size()), 32'(3 + 2 * n));
        check_val({tag, "_out_count"}, 32'(q.size()), 32'(n));
        for (int k = 1; k <= n; k++) begin
            s = (s + k) % 256;
            if (k <= q.size()) check_val({tag, "_out_val"}, 32'(q[k-1]), 32'(s));
        end
        check_val({tag, "_final_sum"}, 32'(rd_data0), 32'(s));
        check_val({tag, "_final_obuf"}, 32'(oOutBufSel), 32'd1);
        check_val({tag, "_r1"}, 32'(rf[R_I]), 32'(n + 1));
        check_val({tag, "_r3"}, 32'(rf[R_ONE]), 32'd1);
        if (n == 0 && wq.size() == 3) begin
            for (int k = 0; k < 3; k++) check_val({tag, "_waddr"}, 32'(wq[k]), 32'(k + 1));
        end
    endtask

    initial begin
        int accs;
        int guard;
        iRst      = 1'b1;
        iStart    = 1'b0;
        alt_force = 1'b0;
        scr       = 1'b0;
        #2;
        check_val("reset_outputs", 32'(outs()), 32'd0);
        repeat (2) @(posedge iClk);
        #1;
        check_val("reset_hold", 32'(outs()), 32'd0);
        iRst = 1'b0;
        scramble();

        repeat ($urandom_range(1, 5)) begin
            @(posedge iClk); #1;
        end
        check_val("idle_not_busy", 32'(oBusy), 32'd0);
        run_once(0, 0, LIMIT, "pulse");
        for (int k = 0; k < 3; k++) begin
            @(posedge iClk); #1;
            check_val("done_hold", 32'(oDone), 32'd1);
            check_val("done_hold_sum", 32'(rd_data0), 32'd55);
        end

        scramble();
        alt_force = 1'b1;
        run_once(0, 0, 0, "alt0");
        alt_force = 1'b0;

        scramble();
        iStart = 1'b1;
        accs = 0;
        guard = 0;
        while (accs < 5 && guard < 100) begin
            @(posedge iClk); #1;
            guard++;
            iStart = 1'b0;
            if (oWe && oRSrcSel && oWAddr == 2'd2 && oRAddr0 == 2'd2) accs++;
        end
        check_val("acc5_reached", 32'(accs), 32'd5);
        iRst = 1'b1;
        #1;
        check_val("midrun_reset", 32'(outs()), 32'd0);
        iRst = 1'b0;
        repeat (2) begin
            @(posedge iClk); #1;
        end
        check_val("post_reset_idle", 32'(outs()), 32'd0);
        run_once(0, 0, LIMIT, "restart");

        run_once(1, 0, LIMIT, "hold1");
        run_once(1, 0, LIMIT, "hold2");
        iStart = 1'b0;

        scramble();
        run_once(0, 1, LIMIT, "toggle1");
        run_once(0, 1, LIMIT, "toggle2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
